// File: rtl/cim_tile_ctrl_if.sv
// Bus bundle for the compute-in-memory tile controller.
// The master side is the host/ADC environment and the slave side is the tile.
interface cim_tile_ctrl_if #(
  parameter int DATA_SIZE      = 8,
  parameter int BUS_WIDTH      = 16,
  parameter int NUM_ADDR       = 16,
  parameter int NUM_COLS       = 32,
  parameter int ADC_WIDTH      = 8,
  parameter int OBUF_DATA_SIZE = ADC_WIDTH + DATA_SIZE + 1
);
  logic                            i_we;
  logic [$clog2(NUM_ADDR)-1:0]     i_addr;
  logic [BUS_WIDTH-1:0]            i_data;
  logic                            i_start;
  logic                            o_ready;
  logic [NUM_ADDR*BUS_WIDTH-1:0]   o_rd_buf;
  logic                            o_xbar_en;
  logic                            o_adc_req;
  logic [$clog2(NUM_COLS)-1:0]     o_adc_sel;
  logic                            i_adc_valid;
  logic [ADC_WIDTH-1:0]            i_adc_data;
  logic                            o_obuf_we;
  logic [$clog2(NUM_COLS)-1:0]     o_obuf_addr;
  logic [OBUF_DATA_SIZE-1:0]       o_obuf_data;
  logic                            o_err;

  modport master (
    output i_we, i_addr, i_data, i_start, i_adc_valid, i_adc_data,
    input  o_ready, o_rd_buf, o_xbar_en, o_adc_req, o_adc_sel,
           o_obuf_we, o_obuf_addr, o_obuf_data, o_err
  );

  modport slave (
    input  i_we, i_addr, i_data, i_start, i_adc_valid, i_adc_data,
    output o_ready, o_rd_buf, o_xbar_en, o_adc_req, o_adc_sel,
           o_obuf_we, o_obuf_addr, o_obuf_data, o_err
  );
endinterface

// File: rtl/cim_tile_ctrl.sv
// Compute-in-memory tile controller: holds the RD (wordline) buffer, settles the
// crossbar per input bit-plane, walks the ADC over every column accumulating a
// shift-and-add MAC, and streams the results to the output buffer after the last plane.
// Optional feature: define CIM_TILE_SIGNED_EN to treat the MSB plane as negative weight
// (two's-complement inputs); otherwise inputs are unsigned.
module cim_tile_ctrl #(
  parameter int DATA_SIZE      = 8,
  parameter int BUS_WIDTH      = 16,
  parameter int NUM_ADDR       = 16,
  parameter int NUM_COLS       = 32,
  parameter int ADC_WIDTH      = 8,
  parameter int OBUF_DATA_SIZE = ADC_WIDTH + DATA_SIZE + 1,
  parameter int SETTLE_CYCLES  = 4
) (
  input logic            clk,
  input logic            rst,
  cim_tile_ctrl_if.slave bus
);
  localparam int ADDR_W  = $clog2(NUM_ADDR);
  localparam int COL_W   = $clog2(NUM_COLS);
  localparam int PLANE_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [PLANE_W-1:0]        plane_q, plane_d;
  logic [SET_W-1:0]          settle_q, settle_d;
  logic                      err_q, err_d;
  logic [BUS_WIDTH-1:0]      rdBuf_q [NUM_ADDR];
  logic [OBUF_DATA_SIZE-1:0] acc_q [NUM_COLS];
  logic                      rdWe;
  logic                      accWe;
  logic                      addrOk;
  logic                      lastCol;
  logic [OBUF_DATA_SIZE-1:0] adcExt;
  logic [OBUF_DATA_SIZE-1:0] accNext;

  assign addrOk  = ({1'b0, bus.i_addr} < (ADDR_W + 1)'(NUM_ADDR));
  assign lastCol = (col_q == COL_W'(NUM_COLS - 1));
  assign adcExt  = OBUF_DATA_SIZE'(bus.i_adc_data);

  // Plane 0 loads the first partial sum; later planes shift the running sum left and add.
  always_comb begin
    accNext = (acc_q[col_q] << 1) + adcExt;
    if (plane_q == '0) begin
`ifdef CIM_TILE_SIGNED_EN
      accNext = {OBUF_DATA_SIZE{1'b0}} - adcExt;
`else
      accNext = adcExt;
`endif
    end
  end

  // Next-state logic: sequencing of settle, column conversion and result write-out, plus sticky errors.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    plane_d  = plane_q;
    settle_d = settle_q;
    err_d    = err_q;
    rdWe     = 1'b0;
    accWe    = 1'b0;
    case (state_q)
      IDLE: begin
        rdWe = bus.i_we && addrOk;
        if (bus.i_start) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = CONVERT;
          col_d   = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      CONVERT: begin
        if (bus.i_adc_valid) begin
          accWe = 1'b1;
          if (lastCol) begin
            col_d = '0;
            if (plane_q == PLANE_W'(DATA_SIZE - 1)) begin
              state_d = WRITE;
            end else begin
              plane_d = plane_q + PLANE_W'(1);
              state_d = IDLE;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      WRITE: begin
        if (lastCol) begin
          col_d   = '0;
          plane_d = '0;
          state_d = IDLE;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && (bus.i_we || bus.i_start)) err_d = 1'b1;
    if ((state_q != CONVERT) && bus.i_adc_valid) err_d = 1'b1;
  end

  // Control state register; reset aborts any activation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      plane_q  <= '0;
      settle_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      plane_q  <= plane_d;
      settle_q <= settle_d;
      err_q    <= err_d;
    end
  end

  // RD buffer storage, written only while the tile is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ADDR; i++) rdBuf_q[i] <= '0;
    end else if (rdWe) begin
      rdBuf_q[bus.i_addr] <= bus.i_data;
    end
  end

  // Per-column accumulators, updated when the ADC returns a conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COLS; i++) acc_q[i] <= '0;
    end else if (accWe) begin
      acc_q[col_q] <= accNext;
    end
  end

  // Outputs decode straight from registered state, so reset forces them immediately.
  always_comb begin
    bus.o_ready     = (state_q == IDLE);
    bus.o_xbar_en   = (state_q == SETTLE) || (state_q == CONVERT);
    bus.o_adc_req   = (state_q == CONVERT);
    bus.o_adc_sel   = (state_q == CONVERT) ? col_q : '0;
    bus.o_obuf_we   = (state_q == WRITE);
    bus.o_obuf_addr = (state_q == WRITE) ? col_q : '0;
    bus.o_obuf_data = (state_q == WRITE) ? acc_q[col_q] : '0;
    bus.o_err       = err_q;
  end

  // Flatten the RD buffer onto the wordline drive bus, word 0 in the low bits.
  always_comb begin
    bus.o_rd_buf = '0;
    for (int i = 0; i < NUM_ADDR; i++) bus.o_rd_buf[i*BUS_WIDTH +: BUS_WIDTH] = rdBuf_q[i];
  end
endmodule

// File: tb/tb_cim_tile_ctrl.sv
// Directed bench for cim_tile_ctrl: two-plane, two-column activations with hand-computed
// MAC results, RD buffer writes, protocol-error cases and reset during write-out.
module tb_cim_tile_ctrl;
  localparam int DS  = 2;
  localparam int BW  = 16;
  localparam int NA  = 16;
  localparam int NC  = 2;
  localparam int AW  = 8;
  localparam int OW  = AW + DS + 1;
  localparam int SC  = 3;

`ifdef CIM_TILE_SIGNED_EN
  localparam logic [31:0] EXP1_A0 = 32'd2043;
  localparam logic [31:0] EXP1_A1 = 32'd2;
  localparam logic [31:0] EXP2_A0 = 32'd2040;
`else
  localparam logic [31:0] EXP1_A0 = 32'd7;
  localparam logic [31:0] EXP1_A1 = 32'd2;
  localparam logic [31:0] EXP2_A0 = 32'd12;
`endif

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  int   failCount;
  int   xbarCycles;
  int   weCount;

  cim_tile_ctrl_if #(.DATA_SIZE(DS), .BUS_WIDTH(BW), .NUM_ADDR(NA), .NUM_COLS(NC),
                     .ADC_WIDTH(AW), .OBUF_DATA_SIZE(OW)) bus ();

  cim_tile_ctrl #(.DATA_SIZE(DS), .BUS_WIDTH(BW), .NUM_ADDR(NA), .NUM_COLS(NC),
                  .ADC_WIDTH(AW), .OBUF_DATA_SIZE(OW), .SETTLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [15:0] data,
                               input logic start);
    bus.i_we    = we;
    bus.i_addr  = addr;
    bus.i_data  = data;
    bus.i_start = start;
    tick();
    bus.i_we    = 1'b0;
    bus.i_start = 1'b0;
  endtask

  task automatic waitAdcReq(input string tag);
    int n = 0;
    while (!bus.o_adc_req && n < 50) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.o_adc_req), 32'd1);
  endtask

  // Called one cycle into a request for column colIdx; answers one cycle after the request.
  task automatic serviceCol(input int colIdx, input logic [7:0] data);
    checkOutput($sformatf("adc_sel_col%0d", colIdx), 32'(bus.o_adc_sel), 32'(colIdx));
    tick();
    bus.i_we        = 1'b0;
    bus.i_adc_valid = 1'b1;
    bus.i_adc_data  = data;
    tick();
    bus.i_adc_valid = 1'b0;
    bus.i_adc_data  = '0;
  endtask

  function automatic logic [31:0] rdWord(input int idx);
    return 32'(bus.o_rd_buf[idx*BW +: BW]);
  endfunction

  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    rst             = 1'b1;
    bus.i_we        = 1'b0;
    bus.i_addr      = '0;
    bus.i_data      = '0;
    bus.i_start     = 1'b0;
    bus.i_adc_valid = 1'b0;
    bus.i_adc_data  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready",     32'(bus.o_ready),     32'd1);
    checkOutput("rst_xbar",      32'(bus.o_xbar_en),   32'd0);
    checkOutput("rst_adc_req",   32'(bus.o_adc_req),   32'd0);
    checkOutput("rst_obuf_we",   32'(bus.o_obuf_we),   32'd0);
    checkOutput("rst_obuf_data", 32'(bus.o_obuf_data), 32'd0);
    checkOutput("rst_err",       32'(bus.o_err),       32'd0);
    checkOutput("rst_rdbuf5",    rdWord(5),            32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Activation 1, plane 0: same-cycle write and start
    applyStimulus(1'b1, 4'd5, 16'hA5A5, 1'b1);
    @(negedge clk);
    checkOutput("ready_low_after_start", 32'(bus.o_ready), 32'd0);
    checkOutput("xbar_settle",           32'(bus.o_xbar_en), 32'd1);
    checkOutput("rdbuf5_in_settle",      rdWord(5), 32'hA5A5);
    xbarCycles = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_adc_req) break;
      if (bus.o_xbar_en) xbarCycles++;
    end
    checkOutput("adc_req_after_settle", 32'(bus.o_adc_req), 32'd1);
    checkOutput("settle_cycles",        32'(xbarCycles),    32'd3);
    checkOutput("xbar_in_convert",      32'(bus.o_xbar_en), 32'd1);

    // Illegal RD write during conversion
    bus.i_we   = 1'b1;
    bus.i_addr = 4'd5;
    bus.i_data = 16'h1234;
    serviceCol(0, 8'd3);
    checkOutput("err_we_in_convert",   32'(bus.o_err), 32'd1);
    checkOutput("rdbuf5_unchanged",    rdWord(5), 32'hA5A5);
    serviceCol(1, 8'd0);
    checkOutput("ready_after_plane0",  32'(bus.o_ready),   32'd1);
    checkOutput("xbar_idle",           32'(bus.o_xbar_en), 32'd0);

    // Activation 1, plane 1
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1);
    waitAdcReq("req_plane1");
    serviceCol(0, 8'd1);
    serviceCol(1, 8'd2);
    checkOutput("w1_we0",   32'(bus.o_obuf_we),   32'd1);
    checkOutput("w1_addr0", 32'(bus.o_obuf_addr), 32'd0);
    checkOutput("w1_data0", 32'(bus.o_obuf_data), EXP1_A0);
    checkOutput("w1_xbar",  32'(bus.o_xbar_en),   32'd0);
    tick();
    checkOutput("w1_we1",   32'(bus.o_obuf_we),   32'd1);
    checkOutput("w1_addr1", 32'(bus.o_obuf_addr), 32'd1);
    checkOutput("w1_data1", 32'(bus.o_obuf_data), EXP1_A1);
    tick();
    checkOutput("w1_done_we",    32'(bus.o_obuf_we), 32'd0);
    checkOutput("w1_done_ready", 32'(bus.o_ready),   32'd1);

    // Activation 2: plane counter restarts at 0
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1);
    waitAdcReq("req_a2_plane0");
    serviceCol(0, 8'd5);
    serviceCol(1, 8'd1);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1);
    waitAdcReq("req_a2_plane1");
    serviceCol(0, 8'd2);
    serviceCol(1, 8'd3);
    checkOutput("w2_we0",   32'(bus.o_obuf_we),   32'd1);
    checkOutput("w2_data0", 32'(bus.o_obuf_data), EXP2_A0);

    // Reset during write-out at address 0
    rst = 1'b1;
    #1;
    checkOutput("rstw_ready",     32'(bus.o_ready),     32'd1);
    checkOutput("rstw_obuf_we",   32'(bus.o_obuf_we),   32'd0);
    checkOutput("rstw_obuf_data", 32'(bus.o_obuf_data), 32'd0);
    checkOutput("rstw_err",       32'(bus.o_err),       32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    weCount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.o_obuf_we) weCount++;
    end
    checkOutput("no_we_after_rst", 32'(weCount),  32'd0);
    checkOutput("rdbuf5_cleared",  rdWord(5),     32'd0);

    // Spurious ADC valid while idle
    bus.i_adc_valid = 1'b1;
    bus.i_adc_data  = 8'h11;
    tick();
    bus.i_adc_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_spurious_valid", 32'(bus.o_err),   32'd1);
    checkOutput("ready_after_spur",   32'(bus.o_ready), 32'd1);

    // Top RD address
    applyStimulus(1'b1, 4'd15, 16'h5A5A, 1'b0);
    @(negedge clk);
    checkOutput("rdbuf15", rdWord(15), 32'h5A5A);
    checkOutput("rdbuf0",  rdWord(0),  32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/cim_tile_ctrl.md
CIM_TILE_CTRL -- requirements
Module: cim_tile_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: input bit-planes per activation (one i_start per plane, MSB first).
REQ-002 SHALL have parameter BUS_WIDTH, default 16: RD buffer word width.
REQ-003 SHALL have parameter NUM_ADDR, default 16: RD buffer depth; address width $clog2(NUM_ADDR).
REQ-004 SHALL have parameter NUM_COLS, default 32: ADC-converted columns per tile.
REQ-005 SHALL have parameter ADC_WIDTH, default 8, and OBUF_DATA_SIZE, default ADC_WIDTH+DATA_SIZE+1.
REQ-006 SHALL have parameter SETTLE_CYCLES, default 4: crossbar settle time.
REQ-007 SHALL have ports: clk in 1 clock; rst in 1 async active-high reset.
REQ-008 SHALL have ports: i_we in 1 RD write; i_addr in $clog2(NUM_ADDR) write address; i_data in BUS_WIDTH write data.
REQ-009 SHALL have ports: i_start in 1 start plane; o_ready out 1 tile idle.
REQ-010 SHALL have ports: o_rd_buf out NUM_ADDR*BUS_WIDTH wordline drive; o_xbar_en out 1 crossbar enable.
REQ-011 SHALL have ports: o_adc_req out 1; o_adc_sel out $clog2(NUM_COLS); i_adc_valid in 1; i_adc_data in ADC_WIDTH.
REQ-012 SHALL have ports: o_obuf_we out 1; o_obuf_addr out $clog2(NUM_COLS); o_obuf_data out OBUF_DATA_SIZE; o_err out 1 sticky protocol error.

Function
REQ-013 SHALL implement states IDLE, SETTLE, CONVERT, WRITE.
REQ-014 IDLE: o_ready=1; i_we with i_addr<NUM_ADDR SHALL write i_data into RD word i_addr at the clock edge; i_addr>=NUM_ADDR SHALL be dropped.
REQ-015 IDLE with i_start=1 SHALL go to SETTLE next cycle; o_ready SHALL be 0 from that cycle.
REQ-016 Same-cycle i_we and i_start in IDLE SHALL commit the write before computing.
REQ-017 SETTLE SHALL hold o_xbar_en=1 for exactly SETTLE_CYCLES cycles, then go to CONVERT.
REQ-018 o_xbar_en SHALL remain 1 through CONVERT and SHALL be 0 in IDLE and WRITE.
REQ-019 CONVERT SHALL, for col=0..NUM_COLS-1 in order, hold o_adc_req=1 and o_adc_sel=col until i_adc_valid=1.
REQ-020 On i_adc_valid, CONVERT SHALL update acc[col]=(acc[col]<<1)+i_adc_data, zero-extended, with acc taken as 0 on plane 0.
REQ-021 i_adc_valid with o_adc_req=0 SHALL be ignored and SHALL set o_err.
REQ-022 After column NUM_COLS-1 on plane<DATA_SIZE-1, the block SHALL increment the plane counter and return to IDLE.
REQ-023 After column NUM_COLS-1 on plane DATA_SIZE-1, the block SHALL go to WRITE.
REQ-024 WRITE SHALL assert o_obuf_we for NUM_COLS consecutive cycles with o_obuf_addr=0..NUM_COLS-1 and o_obuf_data=acc[addr].
REQ-025 WRITE SHALL then clear the plane counter and enter IDLE.
REQ-026 i_we or i_start while o_ready=0 SHALL be ignored and SHALL set o_err.
REQ-027 o_err SHALL clear only on reset.
REQ-028 Accumulation SHALL wrap modulo 2^OBUF_DATA_SIZE.

Reset
REQ-029 Asserting rst SHALL immediately set state IDLE, plane=0, RD buffer=0, acc=0, and o_err=0.
REQ-030 During reset, o_ready SHALL be 1 and o_xbar_en, o_adc_req, o_obuf_we, o_adc_sel, o_obuf_addr, and o_obuf_data SHALL be 0.
REQ-031 rst mid-operation SHALL abort the activation without any further o_obuf_we pulse.

Configuration
REQ-032 With macro CIM_TILE_SIGNED_EN defined, plane 0 (MSB) SHALL load acc[col]=-i_adc_data (two's complement), giving signed-input MAC results.
REQ-033 Without CIM_TILE_SIGNED_EN, plane 0 SHALL load +i_adc_data (unsigned inputs).

Verification
REQ-034 Params DATA_SIZE=2, NUM_COLS=2, SETTLE_CYCLES=3; ADC valid 1 cycle after req. Planes ADC col0=3,1 and col1=0,2 -> WRITE addr0=7, addr1=2.
REQ-035 Same stimulus with CIM_TILE_SIGNED_EN -> addr0=-5, addr1=2.
REQ-036 Pulse i_start: o_ready low next cycle; o_xbar_en high exactly 3 cycles before first o_adc_req.
REQ-037 i_we addr=5 data=0xA5A5 plus i_start same cycle -> o_rd_buf word5=0xA5A5 during SETTLE.
REQ-038 i_we during CONVERT -> RD buffer unchanged and o_err=1; spurious i_adc_valid in IDLE -> o_err=1.
REQ-039 rst during WRITE at addr0 -> no further o_obuf_we; o_ready=1 and o_obuf_we=0 immediately.
